// File: rtl/i2s_serializer.sv
// ----------------------------------------------------------------------------
// i2s_serializer
//
// Purpose:
//   Turns parallel signed L/R samples into a Philips I2S stream (BCK, LRCK,
//   SDATA). It can drive a DAC, or it can be looped back into the capture
//   path. One sample is held in a buffer that is loaded through a
//   valid/ready handshake. At each frame start that sample moves into the
//   frame registers, which stay constant while the frame is shifted out.
//
// Parameters:
//   DATA_WIDTH  sample bits per channel, MSB first (1 .. SLOT_WIDTH-1)
//   SLOT_WIDTH  BCK periods per channel slot (frame = 2*SLOT_WIDTH periods)
//   BCK_HALF    i_clk cycles per BCK half-period (>= 1)
//
// Ports:
//   i_clk       system clock, all logic on rising edge
//   i_rst_n     asynchronous active-low reset
//   i_data_l    left sample
//   i_data_r    right sample
//   i_valid     i_data_l/i_data_r valid this cycle
//   o_ready     holding buffer empty; sample taken when i_valid & o_ready
//   o_bck       bit clock
//   o_lrck      word select, 0 = left slot, 1 = right slot
//   o_sdata     serial data, changes only on BCK falling edges
//   o_underrun  one-cycle pulse: a frame started with an empty buffer
// ----------------------------------------------------------------------------
module i2s_serializer #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned SLOT_WIDTH = 32,
   parameter int unsigned BCK_HALF   = 2
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [DATA_WIDTH-1:0] i_data_l,
   input  logic [DATA_WIDTH-1:0] i_data_r,
   input  logic                  i_valid,
   output logic                  o_ready,
   output logic                  o_bck,
   output logic                  o_lrck,
   output logic                  o_sdata,
   output logic                  o_underrun
);

   localparam int unsigned FRAME_BITS = 2 * SLOT_WIDTH;
   localparam int unsigned B_W        = $clog2(FRAME_BITS);
   localparam int unsigned DIV_W      = (BCK_HALF > 1) ? $clog2(BCK_HALF) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCK_HALF - 1);
   localparam logic [B_W-1:0]   B_LAST   = B_W'(FRAME_BITS - 1);
   localparam logic [B_W-1:0]   B_SLOT   = B_W'(SLOT_WIDTH);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [DIV_W-1:0]      r_div;
   logic                  r_bck;
   logic                  r_lrck;
   logic                  r_sdata;
   logic [B_W-1:0]        r_b;          // bit position within the frame
   logic [DATA_WIDTH-1:0] r_buf_l;
   logic [DATA_WIDTH-1:0] r_buf_r;
   logic                  r_full;
   logic [DATA_WIDTH-1:0] r_frame_l;
   logic [DATA_WIDTH-1:0] r_frame_r;
   logic                  r_underrun;

   // ------------------------------------------------------------------------
   // Combinational next-state
   // ------------------------------------------------------------------------
   logic                  w_div_wrap;
   logic                  w_fall;
   logic                  w_frame_start;
   logic                  w_accept;
   logic [B_W-1:0]        w_b_next;
   logic                  w_right;
   logic [B_W-1:0]        w_pos;
   logic [DATA_WIDTH-1:0] w_chan;
   logic                  w_bit;

   logic [DIV_W-1:0]      w_div_d;
   logic                  w_bck_d;
   logic                  w_lrck_d;
   logic                  w_sdata_d;
   logic [B_W-1:0]        w_b_d;
   logic [DATA_WIDTH-1:0] w_buf_l_d;
   logic [DATA_WIDTH-1:0] w_buf_r_d;
   logic                  w_full_d;
   logic [DATA_WIDTH-1:0] w_frame_l_d;
   logic [DATA_WIDTH-1:0] w_frame_r_d;
   logic                  w_underrun_d;

   // Bit clock divider and frame position decode
   always_comb begin
      w_div_wrap    = (r_div == DIV_LAST);
      w_fall        = w_div_wrap & r_bck;
      w_b_next      = (r_b == B_LAST) ? '0 : r_b + B_W'(1);
      w_right       = (w_b_next >= B_SLOT);
      w_pos         = w_right ? (w_b_next - B_SLOT) : w_b_next;
      w_frame_start = w_fall & (w_b_next == '0);
      w_accept      = i_valid & ~r_full;

      // The channel mux sees the old frame registers even on a frame start.
      // That is harmless because position 0 of a slot is always the blank
      // I2S delay bit.
      w_chan = w_right ? r_frame_r : r_frame_l;

      // Position p (1..DATA_WIDTH) carries bit DATA_WIDTH-p, so the MSB goes
      // out one BCK after the LRCK edge. Every other position is padded with 0.
      w_bit = 1'b0;
      for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
         if (w_pos == B_W'(DATA_WIDTH - i)) begin
            w_bit = w_chan[i];
         end
      end
   end

   always_comb begin
      w_div_d      = w_div_wrap ? '0 : r_div + DIV_W'(1);
      w_bck_d      = w_div_wrap ? ~r_bck : r_bck;
      w_lrck_d     = r_lrck;
      w_sdata_d    = r_sdata;
      w_b_d        = r_b;
      w_buf_l_d    = r_buf_l;
      w_buf_r_d    = r_buf_r;
      w_full_d     = r_full;
      w_frame_l_d  = r_frame_l;
      w_frame_r_d  = r_frame_r;
      w_underrun_d = 1'b0;

      if (w_fall) begin
         w_b_d     = w_b_next;
         w_lrck_d  = w_right;
         w_sdata_d = w_bit;
      end

      // A frame start either moves the buffered sample into the frame
      // registers or sends silence and flags the underrun.
      if (w_frame_start) begin
         w_frame_l_d  = r_full ? r_buf_l : '0;
         w_frame_r_d  = r_full ? r_buf_r : '0;
         w_underrun_d = ~r_full;
         w_full_d     = 1'b0;
      end

      // An accept needs an empty buffer, so it never collides with a load
      // from the buffer. A sample accepted on an underrun frame start waits
      // for the next frame.
      if (w_accept) begin
         w_buf_l_d = i_data_l;
         w_buf_r_d = i_data_r;
         w_full_d  = 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_div      <= '0;
         r_bck      <= 1'b0;
         r_lrck     <= 1'b1;
         r_sdata    <= 1'b0;
         r_b        <= B_LAST;
         r_buf_l    <= '0;
         r_buf_r    <= '0;
         r_full     <= 1'b0;
         r_frame_l  <= '0;
         r_frame_r  <= '0;
         r_underrun <= 1'b0;
      end else begin
         r_div      <= w_div_d;
         r_bck      <= w_bck_d;
         r_lrck     <= w_lrck_d;
         r_sdata    <= w_sdata_d;
         r_b        <= w_b_d;
         r_buf_l    <= w_buf_l_d;
         r_buf_r    <= w_buf_r_d;
         r_full     <= w_full_d;
         r_frame_l  <= w_frame_l_d;
         r_frame_r  <= w_frame_r_d;
         r_underrun <= w_underrun_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign o_ready    = ~r_full;
   assign o_bck      = r_bck;
   assign o_lrck     = r_lrck;
   assign o_sdata    = r_sdata;
   assign o_underrun = r_underrun;

endmodule
